// File: rtl/spram_boot_sequencer.sv
// rtl/spram_boot_sequencer.sv - loads two flash images into the SPRAM banks, then releases the SoC
// SPRAM ports are granted to the loader only while their image is streaming in.
module spram_boot_sequencer #(
   parameter int          ADDR_W      = 14,
   parameter logic [23:0] IMG0_ADDR   = 24'h030000,
   parameter logic [23:0] IMG1_ADDR   = 24'h050000,
   parameter logic [31:0] TERM_WORD   = 32'hFFFF_FFFF,
   parameter int          WAIT_CYCLES = 13
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              ip_done_i,
   output logic              fill_o,
   output logic              fifo_rstn_o,
   output logic [23:0]       flash_addr_o,
   input  logic              spi_we_i,
   input  logic [31:0]       spi_din_i,
   input  logic [ADDR_W-1:0] soc0_addr_i,
   input  logic [31:0]       soc0_din_i,
   input  logic              soc0_we_i,
   input  logic [3:0]        soc0_maskwe_i,
   input  logic              soc0_re_i,
   output logic              soc0_read_valid_o,
   output logic              soc0_write_done_o,
   input  logic [ADDR_W-1:0] soc1_addr_i,
   input  logic [31:0]       soc1_din_i,
   input  logic              soc1_we_i,
   input  logic [3:0]        soc1_maskwe_i,
   input  logic              soc1_re_i,
   output logic              soc1_read_valid_o,
   output logic              soc1_write_done_o,
   output logic [ADDR_W-1:0] ram0_addr_o,
   output logic [31:0]       ram0_din_o,
   output logic              ram0_we_o,
   output logic [3:0]        ram0_maskwe_o,
   output logic [ADDR_W-1:0] ram1_addr_o,
   output logic [31:0]       ram1_din_o,
   output logic              ram1_we_o,
   output logic [3:0]        ram1_maskwe_o,
   output logic              soc_rstn_o,
   output logic              load_done_o,
   output logic              overflow_o
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {LOAD0, GAP, LOAD1, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] wr_addr, wr_addr_nx;
   logic [CNT_W-1:0]  gap_cnt, gap_cnt_nx;
   logic              ovf_set;
   logic              is_term;
   logic              load_we;

   assign is_term = (spi_din_i == TERM_WORD);
   assign load_we = spi_we_i && !is_term;

   always_comb begin
      state_nx   = state;
      wr_addr_nx = wr_addr;
      gap_cnt_nx = gap_cnt;
      ovf_set    = 1'b0;
      case (state)
         LOAD0, LOAD1: begin
            if (spi_we_i) begin
               // The last bank word is still written; running out of space acts like a terminator.
               if (is_term || (&wr_addr)) begin
                  state_nx   = (state == LOAD0) ? GAP : DONE;
                  wr_addr_nx = '0;
                  ovf_set    = !is_term;
               end else begin
                  wr_addr_nx = wr_addr + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
               state_nx   = LOAD1;
               gap_cnt_nx = '0;
            end else begin
               gap_cnt_nx = gap_cnt + 1'b1;
            end
         end
         DONE:    state_nx = DONE;
         default: state_nx = LOAD0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state             <= LOAD0;
         wr_addr           <= '0;
         gap_cnt           <= '0;
         fill_o            <= 1'b0;
         fifo_rstn_o       <= 1'b1;
         load_done_o       <= 1'b0;
         soc_rstn_o        <= 1'b0;
         overflow_o        <= 1'b0;
         soc0_read_valid_o <= 1'b0;
         soc1_read_valid_o <= 1'b0;
      end else begin
         state             <= state_nx;
         wr_addr           <= wr_addr_nx;
         gap_cnt           <= gap_cnt_nx;
         // Status outputs are registered from the next state so they line up with the state itself.
         fill_o            <= (state_nx == LOAD0) || (state_nx == LOAD1);
         fifo_rstn_o       <= (state_nx != GAP);
         load_done_o       <= (state_nx == DONE);
         soc_rstn_o        <= soc_rstn_o || ((state == DONE) && ip_done_i);
         overflow_o        <= overflow_o || ovf_set;
         soc0_read_valid_o <= soc0_re_i;
         soc1_read_valid_o <= soc1_re_i;
      end
   end

   assign flash_addr_o      = (state == LOAD0) ? IMG0_ADDR : IMG1_ADDR;
   assign soc0_write_done_o = soc0_we_i;
   assign soc1_write_done_o = soc1_we_i;

   always_comb begin
      ram0_addr_o   = soc0_addr_i;
      ram0_din_o    = soc0_din_i;
      ram0_we_o     = soc0_we_i;
      ram0_maskwe_o = soc0_maskwe_i;
      if (state == LOAD0) begin
         ram0_addr_o   = wr_addr;
         ram0_din_o    = spi_din_i;
         ram0_we_o     = load_we;
         ram0_maskwe_o = 4'b1111;
      end
   end

   always_comb begin
      ram1_addr_o   = soc1_addr_i;
      ram1_din_o    = soc1_din_i;
      ram1_we_o     = soc1_we_i;
      ram1_maskwe_o = soc1_maskwe_i;
      if (state == LOAD1) begin
         ram1_addr_o   = wr_addr;
         ram1_din_o    = spi_din_i;
         ram1_we_o     = load_we;
         ram1_maskwe_o = 4'b1111;
      end
   end

endmodule
